inst_decode_queue: RTL and testbench

- Dual-lane instruction buffer and decoder between fetch and issue.
- Accepts up to 2 fetched 32-bit MIPS instructions per cycle into a 4-entry circular queue.
- Decodes the two head entries against the shared opcode/funct/regimm-rt encodings.
- Presents up to 2 decoded micro-ops per cycle to issue under a valid/ready handshake.

---
 rtl/inst_decode_queue_pkg.sv | 59 +++++
 rtl/inst_decode_queue_decoder.sv | 82 ++++++++
 rtl/inst_decode_queue.sv | 111 +++++++++++
 tb/tb_inst_decode_queue.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_decode_queue_pkg.sv
// Shared MIPS encodings, micro-op classes and decoded-field layout for the
// dual-lane instruction decode queue.
package inst_decode_queue_pkg;

  typedef enum logic [5:0] {
    OP_R_TYPE = 6'h00,
    OP_REGIMM = 6'h01,
    OP_J      = 6'h02,
    OP_JAL    = 6'h03,
    OP_BEQ    = 6'h04,
    OP_BNE    = 6'h05,
    OP_BLEZ   = 6'h06,
    OP_BGTZ   = 6'h07,
    OP_ADDI   = 6'h08,
    OP_ANDI   = 6'h0C,
    OP_ORI    = 6'h0D,
    OP_XORI   = 6'h0E
  } opcode_t;

  typedef enum logic [5:0] {
    F_JR   = 6'h08,
    F_JALR = 6'h09,
    F_ADD  = 6'h20,
    F_ADDU = 6'h21,
    F_SUB  = 6'h22,
    F_AND  = 6'h24,
    F_OR   = 6'h25,
    F_XOR  = 6'h26,
    F_NOR  = 6'h27
  } funct_t;

  typedef enum logic [4:0] {
    RT_BLTZ   = 5'h00,
    RT_BGEZ   = 5'h01,
    RT_BLTZAL = 5'h10,
    RT_BGEZAL = 5'h11
  } Rt_funct_t;

  typedef enum logic [2:0] {
    ALU_R    = 3'd0,
    ALU_I    = 3'd1,
    BRANCH   = 3'd2,
    JUMP     = 3'd3,
    JUMP_REG = 3'd4,
    ILLEGAL  = 3'd7
  } uop_class_t;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef struct packed {
    uop_class_t  cls;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] imm;
    logic [25:0] target;
  } decoded_t;

endpackage

// File: rtl/inst_decode_queue_decoder.sv
// Pure combinational decode of one 32-bit MIPS instruction into micro-op fields.
module inst_decoder
  import inst_decode_queue_pkg::*;
(
  input  logic [31:0] inst,
  output decoded_t    dec
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] sext;
  logic [31:0] zext;

  assign op   = inst[31:26];
  assign fn   = inst[5:0];
  assign rt   = inst[20:16];
  assign rd   = inst[15:11];
  assign sext = {{16{inst[15]}}, inst[15:0]};
  assign zext = {16'h0000, inst[15:0]};

  // NOTE: every field gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    dec        = '0;
    dec.cls    = ILLEGAL;
    dec.rs     = inst[25:21];
    dec.rt     = rt;
    dec.target = inst[25:0];
    case (op)
      OP_R_TYPE: begin
        case (fn)
          F_ADD, F_ADDU, F_AND, F_NOR, F_OR, F_SUB, F_XOR: begin
            dec.cls = ALU_R;
            dec.dst = rd;
          end
          F_JR:    dec.cls = JUMP_REG;
          F_JALR: begin
            dec.cls = JUMP_REG;
            dec.dst = rd;
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: begin
            dec.cls = BRANCH;
            dec.imm = sext;
          end
          RT_BLTZAL, RT_BGEZAL: begin
            dec.cls = BRANCH;
            dec.imm = sext;
            dec.dst = LINK_REG;
          end
          default: ;
        endcase
      end
      OP_J:   dec.cls = JUMP;
      OP_JAL: begin
        dec.cls = JUMP;
        dec.dst = LINK_REG;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        dec.cls = BRANCH;
        dec.imm = sext;
      end
      OP_ADDI: begin
        dec.cls = ALU_I;
        dec.imm = sext;
        dec.dst = rt;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.cls = ALU_I;
        dec.imm = zext;
        dec.dst = rt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_decode_queue.sv
// Dual-lane fetch-to-issue instruction queue with per-lane decode.
// Optional macro SINGLE_BRANCH_ISSUE_EN: a control-flow op in lane 0 issues alone.
module inst_decode_queue
  import inst_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [LANES-1:0] in_valid,
  input  logic [31:0]      in_inst0,
  input  logic [31:0]      in_inst1,
  input  logic [31:0]      in_pc,
  output logic             in_ready,
  output logic [LANES-1:0] out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc0,
  output logic [31:0]      out_pc1,
  output uop_class_t       out_class0,
  output uop_class_t       out_class1,
  output logic [4:0]       out_rs0,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rt0,
  output logic [4:0]       out_rt1,
  output logic [4:0]       out_dst0,
  output logic [4:0]       out_dst1,
  output logic [31:0]      out_imm0,
  output logic [31:0]      out_imm1,
  output logic [25:0]      out_target0,
  output logic [25:0]      out_target1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr1, rd_ptr1;
  logic [CW-1:0] count, push_n, pop_n;
  logic          push_en, lane0_ok, lane1_ok;
  decoded_t      dec0, dec1;

  assign in_ready = (count <= CW'(DEPTH - 2));
  assign push_en  = in_valid[0] && in_ready;
  assign push_n   = push_en ? (in_valid[1] ? CW'(2) : CW'(1)) : '0;
  assign wr_ptr1  = wr_ptr + AW'(1);
  assign rd_ptr1  = rd_ptr + AW'(1);

  // NOTE: storage is data only; validity lives in count, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push_en && !flush) begin
      inst_mem[wr_ptr] <= in_inst0;
      pc_mem[wr_ptr]   <= in_pc;
      if (in_valid[1]) begin
        inst_mem[wr_ptr1] <= in_inst1;
        pc_mem[wr_ptr1]   <= in_pc + 32'd4;
      end
    end
  end

  inst_decoder u_dec0 (.inst(inst_mem[rd_ptr]),  .dec(dec0));
  inst_decoder u_dec1 (.inst(inst_mem[rd_ptr1]), .dec(dec1));

  assign lane0_ok = (count >= CW'(1));
`ifdef SINGLE_BRANCH_ISSUE_EN
  assign lane1_ok = (count >= CW'(2)) && !(dec0.cls inside {BRANCH, JUMP, JUMP_REG});
`else
  assign lane1_ok = (count >= CW'(2));
`endif

  assign out_valid = {lane1_ok, lane0_ok};
  assign pop_n     = !out_ready ? '0 : lane1_ok ? CW'(2) : lane0_ok ? CW'(1) : '0;

  // Invalid lanes present all-zero fields so issue never sees stale data.
  always_comb begin
    out_pc0 = '0; out_class0 = ALU_R; out_rs0 = '0; out_rt0 = '0;
    out_dst0 = '0; out_imm0 = '0; out_target0 = '0;
    out_pc1 = '0; out_class1 = ALU_R; out_rs1 = '0; out_rt1 = '0;
    out_dst1 = '0; out_imm1 = '0; out_target1 = '0;
    if (lane0_ok) begin
      out_pc0 = pc_mem[rd_ptr];  out_class0 = dec0.cls; out_rs0 = dec0.rs;
      out_rt0 = dec0.rt;         out_dst0 = dec0.dst;   out_imm0 = dec0.imm;
      out_target0 = dec0.target;
    end
    if (lane1_ok) begin
      out_pc1 = pc_mem[rd_ptr1]; out_class1 = dec1.cls; out_rs1 = dec1.rs;
      out_rt1 = dec1.rt;         out_dst1 = dec1.dst;   out_imm1 = dec1.imm;
      out_target1 = dec1.target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + push_n - pop_n;
    end
  end

endmodule

// File: tb/tb_inst_decode_queue.sv
// Randomized self-checking bench for inst_decode_queue against a queue-based reference model.
module tb_inst_decode_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_ready, out_ready;
  logic [1:0]  in_valid, out_valid;
  logic [31:0] in_inst0, in_inst1, in_pc;
  logic [31:0] out_pc0, out_pc1, out_imm0, out_imm1;
  logic [2:0]  out_class0, out_class1;
  logic [4:0]  out_rs0, out_rs1, out_rt0, out_rt1, out_dst0, out_dst1;
  logic [25:0] out_target0, out_target1;

  inst_decode_queue #(.DEPTH(DEPTH), .LANES(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_inst0(in_inst0), .in_inst1(in_inst1), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .out_class0(out_class0), .out_class1(out_class1),
    .out_rs0(out_rs0), .out_rs1(out_rs1), .out_rt0(out_rt0), .out_rt1(out_rt1),
    .out_dst0(out_dst0), .out_dst1(out_dst1), .out_imm0(out_imm0), .out_imm1(out_imm1),
    .out_target0(out_target0), .out_target1(out_target1)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } entry_t;
  typedef struct { logic [2:0] cls; logic [4:0] dst; logic [31:0] imm; } ref_t;

  entry_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Class numbering: 0 ALU_R, 1 ALU_I, 2 BRANCH, 3 JUMP, 4 JUMP_REG, 7 ILLEGAL.
  function automatic ref_t ref_dec(input logic [31:0] i);
    ref_t r;
    int op = int'(i[31:26]);
    int fn = int'(i[5:0]);
    int rt = int'(i[20:16]);
    logic [31:0] sx = 32'($signed(i[15:0]));
    logic [31:0] zx = {16'h0, i[15:0]};
    r = '{3'd7, 5'd0, 32'd0};
    if (op == 0) begin
      if (fn inside {32, 33, 34, 36, 37, 38, 39}) r = '{3'd0, i[15:11], 32'd0};
      else if (fn == 8)                          r = '{3'd4, 5'd0, 32'd0};
      else if (fn == 9)                          r = '{3'd4, i[15:11], 32'd0};
    end else if (op == 1) begin
      if (rt inside {0, 1})        r = '{3'd2, 5'd0, sx};
      else if (rt inside {16, 17}) r = '{3'd2, 5'd31, sx};
    end
    else if (op == 2)              r = '{3'd3, 5'd0, 32'd0};
    else if (op == 3)              r = '{3'd3, 5'd31, 32'd0};
    else if (op inside {[4:7]})    r = '{3'd2, 5'd0, sx};
    else if (op == 8)              r = '{3'd1, i[20:16], sx};
    else if (op inside {[12:14]})  r = '{3'd1, i[20:16], zx};
    return r;
  endfunction

  function automatic int exp_lanes();
    int n = (q.size() >= 2) ? 2 : q.size();
`ifdef SINGLE_BRANCH_ISSUE_EN
    if (n == 2 && ref_dec(q[0].inst).cls inside {3'd2, 3'd3, 3'd4}) n = 1;
`endif
    return n;
  endfunction

  task automatic check_lane(input string tag, input bit present, input entry_t e,
                            input logic [31:0] pc, input logic [2:0] cls,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                            input logic [31:0] imm, input logic [25:0] tgt);
    ref_t r = ref_dec(e.inst);
    if (present) begin
      check({tag, ".pc"},  pc,  e.pc);
      check({tag, ".cls"}, cls, r.cls);
      check({tag, ".rs"},  rs,  e.inst[25:21]);
      check({tag, ".rt"},  rt,  e.inst[20:16]);
      check({tag, ".dst"}, dst, r.dst);
      check({tag, ".imm"}, imm, r.imm);
      check({tag, ".tgt"}, tgt, e.inst[25:0]);
    end else begin
      check({tag, ".zero"}, {pc ^ imm, 3'd0}, 35'd0);
      check({tag, ".zfld"}, {cls, rs, rt, dst, tgt}, 44'd0);
    end
  endtask

  task automatic check_outputs(input string tag);
    int n = exp_lanes();
    entry_t e0 = '{32'd0, 32'd0};
    entry_t e1 = '{32'd0, 32'd0};
    if (q.size() > 0) e0 = q[0];
    if (q.size() > 1) e1 = q[1];
    check({tag, ".in_ready"}, in_ready, q.size() <= DEPTH - 2);
    check({tag, ".out_valid"}, out_valid, (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00);
    check_lane({tag, ".l0"}, n >= 1, e0, out_pc0, out_class0, out_rs0, out_rt0, out_dst0,
               out_imm0, out_target0);
    check_lane({tag, ".l1"}, n >= 2, e1, out_pc1, out_class1, out_rs1, out_rt1, out_dst1,
               out_imm1, out_target1);
  endtask

  // Called in the low clock phase: drive, check the current state, clock once, update model.
  task automatic step(input string tag, input logic [1:0] v, input logic [31:0] i0,
                      input logic [31:0] i1, input logic [31:0] pc, input logic rdy,
                      input logic fl);
    int n;
    bit can_push;
    in_valid = v; in_inst0 = i0; in_inst1 = i1; in_pc = pc; out_ready = rdy; flush = fl;
    #1;
    check_outputs(tag);
    n = exp_lanes();
    can_push = q.size() <= DEPTH - 2;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (rdy) repeat (n) void'(q.pop_front());
      if (v[0] && can_push) begin
        q.push_back('{i0, pc});
        if (v[1]) q.push_back('{i1, pc + 32'd4});
      end
    end
    @(negedge clk);
    in_valid = 2'b00; flush = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget = 10;
    while (q.size() > 0 && budget > 0) begin
      step(tag, 2'b00, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      budget--;
    end
    check({tag, ".drained"}, q.size(), 0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                             6'h06, 6'h07, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23};
    logic [5:0] fns [11] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h08, 6'h09, 6'h00, 6'h2A};
    logic [4:0] rts [5]  = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h05};
    logic [31:0] i = $urandom();
    if ($urandom_range(0, 7) != 0) i[31:26] = ops[$urandom_range(0, 13)];
    if (i[31:26] == 6'h00) i[5:0]   = fns[$urandom_range(0, 10)];
    if (i[31:26] == 6'h01) i[20:16] = rts[$urandom_range(0, 4)];
    return i;
  endfunction

  initial begin
    logic [31:0] pc;
    int budget;
    rst = 1'b1; flush = 1'b0; in_valid = 2'b00; out_ready = 1'b0;
    in_inst0 = '0; in_inst1 = '0; in_pc = '0;
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // ALU_I pair: sign- and zero-extended immediates
    step("alui", 2'b11, 32'h20010005, 32'h3422FFFF, 32'h1000, 1'b0, 1'b0);
    #1;
    check("alui.valid", out_valid, 2'b11);
    check("alui.c0", out_class0, 3'd1);
    check("alui.rt0", out_rt0, 5'd1);
    check("alui.d0", out_dst0, 5'd1);
    check("alui.i0", out_imm0, 32'h5);
    check("alui.c1", out_class1, 3'd1);
    check("alui.d1", out_dst1, 5'd2);
    check("alui.i1", out_imm1, 32'h0000FFFF);

    // Beq + Add while the ALU_I pair issues
    step("br", 2'b11, 32'h1022FFFF, 32'h00221820, 32'h1008, 1'b1, 1'b0);
    #1;
    check("br.c0", out_class0, 3'd2);
    check("br.i0", out_imm0, 32'hFFFFFFFF);
    check("br.d0", out_dst0, 5'd0);
`ifdef SINGLE_BRANCH_ISSUE_EN
    check("br.valid", out_valid, 2'b01);
`else
    check("br.valid", out_valid, 2'b11);
    check("br.c1", out_class1, 3'd0);
    check("br.d1", out_dst1, 5'd3);
`endif
    step("br_pop", 2'b00, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    drain("d1");

    // Jal + Bltzal, then an unknown opcode
    step("jal", 2'b11, 32'h0C000100, 32'h04300004, 32'h2000, 1'b0, 1'b0);
    #1;
    check("jal.c0", out_class0, 3'd3);
    check("jal.t0", out_target0, 26'h100);
    check("jal.d0", out_dst0, 5'd31);
    check("bltzal.c", out_class0 == 3'd3 && out_valid[1] ? out_class1 : 3'd2, 3'd2);
    drain("d2");
    step("lw", 2'b01, 32'h8C220000, 32'd0, 32'h3000, 1'b0, 1'b0);
    #1;
    check("lw.c0", out_class0, 3'd7);
    check("lw.i0", out_imm0, 32'd0);
    drain("d3");

    // Fill to full with issue stalled, then drain across the pointer wrap
    pc = 32'h5000;
    budget = 8;
    while (in_ready && budget > 0) begin
      step("fill", 2'b11, rand_inst(), rand_inst(), pc, 1'b0, 1'b0);
      pc += 8; budget--;
    end
    #1;
    check("full.in_ready", in_ready, 1'b0);
    step("full_ignore", 2'b11, rand_inst(), rand_inst(), pc, 1'b0, 1'b0);
    check("full.size", q.size(), DEPTH);
    drain("wrap");

    // Flush with a simultaneous push drops everything
    step("pre_flush", 2'b11, rand_inst(), rand_inst(), 32'h6000, 1'b0, 1'b0);
    step("flush", 2'b11, rand_inst(), rand_inst(), 32'h6008, 1'b0, 1'b1);
    #1;
    check("flush.valid", out_valid, 2'b00);
    check("flush.in_ready", in_ready, 1'b1);

    // Asynchronous reset with three entries queued
    step("pre_rst0", 2'b11, rand_inst(), rand_inst(), 32'h7000, 1'b0, 1'b0);
    step("pre_rst1", 2'b01, rand_inst(), 32'd0, 32'h7008, 1'b0, 1'b0);
    check("pre_rst.size", q.size(), 3);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    check("arst.valid", out_valid, 2'b00);
    check("arst.pc0", out_pc0, 32'd0);
    check("arst.in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 2'b11, 32'h20010005, 32'h3422FFFF, 32'h8000, 1'b0, 1'b0);
    #1;
    check("post_rst.pc0", out_pc0, 32'h8000);
    check("post_rst.pc1", out_pc1, 32'h8004);

    // Randomized traffic
    pc = 32'h10000;
    for (int k = 0; k < 400; k++) begin
      logic [1:0] v;
      v = ($urandom_range(0, 3) == 0) ? 2'b00 : ($urandom_range(0, 2) == 0) ? 2'b01 : 2'b11;
      step("rand", v, rand_inst(), rand_inst(), pc, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 24) == 0));
      pc += 8;
    end
    drain("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
